// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier and its users (stall controller, bench).
// Latency constants count edges from the first edge that sees the request to complete high.
package mul_pkg;

    localparam int MUL_WIDTH   = 32;
    localparam int MUL_ITER_R2 = MUL_WIDTH;
    localparam int MUL_ITER_R4 = MUL_WIDTH / 2;
    localparam int MUL_LAT_R2  = MUL_WIDTH + 2;
    localparam int MUL_LAT_R4  = MUL_WIDTH / 2 + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mul_state_t;

endpackage

// File: rtl/mul_iter_twos_neg.sv
// Conditional two's-complement negation: dout = en ? -din : din.
// Purely combinational, zero latency, no flow control.
module twos_neg #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, signed/unsigned, full 2*WIDTH product on hi/lo.
// Latency WIDTH+2 edges (WIDTH/2+2 with MUL_RADIX4_EN); request is level-held, dropping it aborts.
// Backpressure: complete stays high while mul is held; a new operation needs mul low for one edge.
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             mul_clk,
    input  logic             resetn,
    input  logic             mul,
    input  logic             mul_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             complete
);

`ifdef MUL_RADIX4_EN
    localparam int ITERS = WIDTH / 2;
`else
    localparam int ITERS = WIDTH;
`endif

    mul_state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic [2*WIDTH-1:0] prod_fix;

    twos_neg #(.W(WIDTH)) u_neg_x (
        .en   (mul_signed & x[WIDTH-1]),
        .din  (x),
        .dout (x_mag)
    );

    twos_neg #(.W(WIDTH)) u_neg_y (
        .en   (mul_signed & y[WIDTH-1]),
        .din  (y),
        .dout (y_mag)
    );

    twos_neg #(.W(2*WIDTH)) u_neg_p (
        .en   (neg),
        .din  ({acc, mplier}),
        .dout (prod_fix)
    );

    // Partial-product sum is one (radix-2) or two (radix-4) bits wider than acc so the carry
    // shifts down into acc; after the shift acc always fits back in WIDTH bits.
`ifdef MUL_RADIX4_EN
    logic [WIDTH+1:0] mcand3;
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum;

    always_comb begin
        addend = '0;
        case (mplier[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = {2'b00, mcand};
            2'd2:    addend = {1'b0, mcand, 1'b0};
            default: addend = mcand3;
        endcase
        sum = {2'b00, acc} + addend;
    end
`else
    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    end
`endif

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (mul) state_nxt = CALC;
            CALC:  begin
                if (!mul)                   state_nxt = IDLE;
                else if (cnt == CNT_W'(1))  state_nxt = FIXUP;
            end
            FIXUP: state_nxt = mul ? DONE : IDLE;
            DONE:  if (!mul) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            complete <= 1'b0;
`ifdef MUL_RADIX4_EN
            mcand3   <= '0;
`endif
        end else begin
            // complete tracks entry to / residence in DONE; any other next state clears it.
            complete <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (mul) begin
                        mcand  <= x_mag;
                        mplier <= y_mag;
                        neg    <= mul_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CNT_W'(ITERS);
`ifdef MUL_RADIX4_EN
                        mcand3 <= {2'b00, x_mag} + {1'b0, x_mag, 1'b0};
`endif
                    end
                end
                CALC: begin
`ifdef MUL_RADIX4_EN
                    acc    <= sum[WIDTH+1:2];
                    mplier <= {sum[1:0], mplier[WIDTH-1:2]};
`else
                    acc    <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
`endif
                    cnt    <= cnt - CNT_W'(1);
                end
                FIXUP: begin
                    if (mul) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Directed self-checking bench for mul_iter: corner products, latency, hold, abort, async reset.
module tb_mul_iter;
    import mul_pkg::*;

    localparam int W = 32;
`ifdef MUL_RADIX4_EN
    localparam int EXP_LAT = MUL_LAT_R4;
`else
    localparam int EXP_LAT = MUL_LAT_R2;
`endif

    logic         mul_clk    = 1'b0;
    logic         resetn     = 1'b0;
    logic         mul        = 1'b0;
    logic         mul_signed = 1'b0;
    logic [W-1:0] x          = '0;
    logic [W-1:0] y          = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         complete;

    int total = 0;
    int bad   = 0;
    int lat;

    mul_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .mul        (mul),
        .mul_signed (mul_signed),
        .x          (x),
        .y          (y),
        .hi         (hi),
        .lo         (lo),
        .complete   (complete)
    );

    always #5 mul_clk = ~mul_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge mul_clk);
        x          = a;
        y          = b;
        mul_signed = s;
        mul        = 1'b1;
    endtask

    // Counts edges from the start edge until complete; 200 means it never came.
    // When chg_at > 0 the operands are scrambled after that many edges.
    task automatic wait_done(input int chg_at, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge mul_clk);
            #1;
            n++;
            if (n == chg_at) begin
                x          = 32'hDEAD_BEEF;
                y          = 32'h0BAD_F00D;
                mul_signed = ~mul_signed;
            end
            if (complete) break;
        end
        if (!complete) n = 200;
    endtask

    task automatic stop_op(input string tag);
        @(negedge mul_clk);
        mul = 1'b0;
        @(posedge mul_clk);
        #1;
        chk(tag, 64'(complete), 64'd0);
    endtask

    initial begin
        #1;
        chk("rst_prod", {hi, lo}, 64'h0);
        chk("rst_complete", 64'(complete), 64'd0);
        @(negedge mul_clk);
        resetn = 1'b1;

        // Unsigned max*max, then hold the request and confirm nothing restarts.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(0, lat);
        chk("umax_lat", 64'(lat), 64'(EXP_LAT));
        chk("umax_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        for (int i = 0; i < 5; i++) begin
            @(posedge mul_clk);
            #1;
            chk("hold_complete", 64'(complete), 64'd1);
        end
        chk("hold_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        stop_op("drop_complete");

        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(0, lat);
        chk("smin_lat", 64'(lat), 64'(EXP_LAT));
        chk("smin_prod", {hi, lo}, 64'h4000_0000_0000_0000);
        stop_op("smin_drop");

        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_done(0, lat);
        chk("neg1_lat", 64'(lat), 64'(EXP_LAT));
        chk("neg1_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        stop_op("neg1_drop");

        start_op(32'hFFFF_FFF9, 32'h0000_0000, 1'b1);
        wait_done(0, lat);
        chk("negzero_prod", {hi, lo}, 64'h0);
        stop_op("negzero_drop");

        // Operands scrambled mid-CALC must not disturb the result.
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_done(6, lat);
        chk("mix_lat", 64'(lat), 64'(EXP_LAT));
        chk("mix_prod", {hi, lo}, 64'h0B00_EA4E_242D_2080);
        stop_op("mix_drop");

        // Abort after 10 CALC edges: no complete, previous result retained.
        start_op(32'h0000_0003, 32'hFFFF_FFFB, 1'b1);
        repeat (11) @(posedge mul_clk);
        @(negedge mul_clk);
        mul = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge mul_clk);
            #1;
            chk("abort_complete", 64'(complete), 64'd0);
        end
        chk("abort_prod", {hi, lo}, 64'h0B00_EA4E_242D_2080);

        start_op(32'h0000_0003, 32'hFFFF_FFFB, 1'b1);
        wait_done(0, lat);
        chk("restart_lat", 64'(lat), 64'(EXP_LAT));
        chk("restart_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Asynchronous reset in the middle of CALC clears outputs without a clock edge.
        stop_op("pre_rst_drop");
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (5) @(posedge mul_clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_prod", {hi, lo}, 64'h0);
        chk("arst_complete", 64'(complete), 64'd0);
        mul = 1'b0;
        @(negedge mul_clk);
        resetn = 1'b1;

        start_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done(0, lat);
        chk("post_rst_lat", 64'(lat), 64'(EXP_LAT));
        chk("post_rst_prod", {hi, lo}, 64'hC000_0000_8000_0000);
        stop_op("post_rst_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
